alu_issue_stage: RTL and testbench

- Registered issue/retire wrapper directly upstream of the 32-bit ripple ALU built from the 1-bit slices.
- Accepts an abstract op code plus operands over a valid/ready handshake.
- Decodes the op into the ALU's control lines: A_invert, B_invert, operation[1:0], compare select, and carry-in.
- Registers the operands, captures the ALU's combinational result and flags, and presents them downstream with back-pressure.
- Two-stage pipeline, 1 op/cycle throughput.

---
 rtl/alu_issue_pkg.sv | 35 +++
 rtl/alu_issue_stage_if.sv | 54 +++++
 rtl/alu_op_decode.sv | 43 ++++
 rtl/alu_issue_stage.sv | 145 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage.
//   - OP_*   : abstract 4-bit op codes accepted on the request channel.
//   - CTRL_* : {A_invert, B_invert, operation[1:0]} patterns for the ALU slices.
//   - CMP_*  : compare-select patterns for the ALU's set-on-compare logic.
package alu_issue_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SGT  = 4'd7;
    localparam logic [3:0] OP_SLE  = 4'd8;
    localparam logic [3:0] OP_SGE  = 4'd9;
    localparam logic [3:0] OP_SEQ  = 4'd10;
    localparam logic [3:0] OP_SNE  = 4'd11;

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_NAND = 4'b1101;
    localparam logic [3:0] CTRL_CMP  = 4'b0111;

    localparam logic [2:0] CMP_SLT = 3'b000;
    localparam logic [2:0] CMP_SGT = 3'b001;
    localparam logic [2:0] CMP_SLE = 3'b010;
    localparam logic [2:0] CMP_SGE = 3'b011;
    localparam logic [2:0] CMP_SEQ = 3'b110;
    localparam logic [2:0] CMP_SNE = 3'b100;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bus bundle for alu_issue_stage.
//   in_*  : request channel (valid/ready, op, two operands) from upstream.
//   alu_* : registered control/operands to the ripple ALU and its
//           combinational result/flags coming back.
//   out_* : result channel (valid/ready, result, flags, illegal) downstream.
// Modports:
//   slave  : the issue stage's view.
//   master : the surrounding environment (upstream, ALU, downstream).
interface alu_issue_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_src1;
    logic [WIDTH-1:0] in_src2;

    logic [WIDTH-1:0] alu_src1;
    logic [WIDTH-1:0] alu_src2;
    logic [3:0]       alu_ctrl;
    logic [2:0]       alu_bonus;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_cout;
    logic             alu_overflow;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_cout;
    logic             out_overflow;
    logic             out_illegal;

    modport slave (
        input  in_valid, in_op, in_src1, in_src2,
        output in_ready,
        output alu_src1, alu_src2, alu_ctrl, alu_bonus, alu_cin,
        input  alu_result, alu_zero, alu_cout, alu_overflow,
        output out_valid, out_result, out_zero, out_cout, out_overflow, out_illegal,
        input  out_ready
    );

    modport master (
        output in_valid, in_op, in_src1, in_src2,
        input  in_ready,
        input  alu_src1, alu_src2, alu_ctrl, alu_bonus, alu_cin,
        output alu_result, alu_zero, alu_cout, alu_overflow,
        input  out_valid, out_result, out_zero, out_cout, out_overflow, out_illegal,
        output out_ready
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational op decoder for the ALU issue stage.
//   op      in  4  abstract op code
//   ctrl    out 4  {A_invert, B_invert, operation[1:0]}
//   bonus   out 3  compare select
//   cin     out 1  carry-in to slice 0 (equals B_invert)
//   illegal out 1  op code 12..15; decodes as ADD
module alu_op_decode
    import alu_issue_pkg::*;
(
    input  logic [3:0] op,
    output logic [3:0] ctrl,
    output logic [2:0] bonus,
    output logic       cin,
    output logic       illegal
);

    always_comb begin
        ctrl    = CTRL_ADD;
        // 000 is inert for non-compare ops since the ALU only looks at it
        // when operation selects the compare input.
        bonus   = CMP_SLT;
        illegal = 1'b0;
        case (op)
            OP_AND:  ctrl = CTRL_AND;
            OP_OR:   ctrl = CTRL_OR;
            OP_ADD:  ctrl = CTRL_ADD;
            OP_SUB:  ctrl = CTRL_SUB;
            OP_NOR:  ctrl = CTRL_NOR;
            OP_NAND: ctrl = CTRL_NAND;
            OP_SLT:  begin ctrl = CTRL_CMP; bonus = CMP_SLT; end
            OP_SGT:  begin ctrl = CTRL_CMP; bonus = CMP_SGT; end
            OP_SLE:  begin ctrl = CTRL_CMP; bonus = CMP_SLE; end
            OP_SGE:  begin ctrl = CTRL_CMP; bonus = CMP_SGE; end
            OP_SEQ:  begin ctrl = CTRL_CMP; bonus = CMP_SEQ; end
            OP_SNE:  begin ctrl = CTRL_CMP; bonus = CMP_SNE; end
            default: illegal = 1'b1;
        endcase
    end

    // Subtraction and compares need a+~b+1, so carry-in tracks B_invert.
    assign cin = ctrl[2];

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage registered issue/retire wrapper around the 32-bit ripple ALU.
//   clk_i  : clock, rising edge.
//   rst_n  : synchronous active-low reset; discards all in-flight ops.
//   bus    : alu_issue_stage_if.slave -- request channel, ALU control/result
//            bus, and result channel with back-pressure.
// Optional build macro ALU_ISSUE_PERF_EN adds:
//   perf_ops[15:0]     : count of retired results (out_valid && out_ready).
//   perf_illegal[15:0] : count of retired results flagged illegal.
// Stage 1 (_p1) holds the decoded op and operands driving the ALU; stage 2
// (_p2) captures the ALU result. Throughput is one op per cycle.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    alu_issue_stage_if.slave bus
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [15:0]      perf_ops,
    output logic [15:0]      perf_illegal
`endif
);

    logic [3:0]       dec_ctrl;
    logic [2:0]       dec_bonus;
    logic             dec_cin;
    logic             dec_illegal;

    logic             vld_p1;
    logic [WIDTH-1:0] src1_p1;
    logic [WIDTH-1:0] src2_p1;
    logic [3:0]       ctrl_p1;
    logic [2:0]       bonus_p1;
    logic             cin_p1;
    logic             illegal_p1;

    logic             vld_p2;
    logic [WIDTH-1:0] result_p2;
    logic             zero_p2;
    logic             cout_p2;
    logic             ovf_p2;
    logic             illegal_p2;

    logic             s2_free;
    logic             in_ready;
    logic             accept;
    logic             s1_to_s2;

    alu_op_decode u_decode (
        .op      (bus.in_op),
        .ctrl    (dec_ctrl),
        .bonus   (dec_bonus),
        .cin     (dec_cin),
        .illegal (dec_illegal)
    );

    // Stage 2 can take a new result if empty or draining this cycle.
    assign s2_free  = !vld_p2 || bus.out_ready;
    // Reads 1 while in reset; the reset branch wins so nothing is captured.
    assign in_ready = !rst_n || !vld_p1 || s2_free;
    assign accept   = bus.in_valid && in_ready;
    assign s1_to_s2 = vld_p1 && s2_free;

    // ---- Stage 1: decode + operand registers feeding the ALU ----
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            src1_p1    <= '0;
            src2_p1    <= '0;
            ctrl_p1    <= 4'b0000;
            bonus_p1   <= 3'b000;
            cin_p1     <= 1'b0;
            illegal_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1     <= 1'b1;
            src1_p1    <= bus.in_src1;
            src2_p1    <= bus.in_src2;
            ctrl_p1    <= dec_ctrl;
            bonus_p1   <= dec_bonus;
            cin_p1     <= dec_cin;
            illegal_p1 <= dec_illegal;
        end else if (s1_to_s2) begin
            vld_p1     <= 1'b0;
        end
    end

    // ---- Stage 2: capture ALU result and flags ----
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            vld_p2     <= 1'b0;
            result_p2  <= '0;
            zero_p2    <= 1'b0;
            cout_p2    <= 1'b0;
            ovf_p2     <= 1'b0;
            illegal_p2 <= 1'b0;
        end else if (s1_to_s2) begin
            vld_p2     <= 1'b1;
            illegal_p2 <= illegal_p1;
            // Illegal ops still run through the ALU as ADD; squash what comes back.
            if (illegal_p1) begin
                result_p2 <= '0;
                zero_p2   <= 1'b0;
                cout_p2   <= 1'b0;
                ovf_p2    <= 1'b0;
            end else begin
                result_p2 <= bus.alu_result;
                zero_p2   <= bus.alu_zero;
                cout_p2   <= bus.alu_cout;
                ovf_p2    <= bus.alu_overflow;
            end
        end else if (bus.out_ready) begin
            vld_p2     <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            perf_ops     <= 16'd0;
            perf_illegal <= 16'd0;
        end else if (vld_p2 && bus.out_ready) begin
            perf_ops <= perf_ops + 16'd1;
            if (illegal_p2) begin
                perf_illegal <= perf_illegal + 16'd1;
            end
        end
    end
`endif

    assign bus.in_ready     = in_ready;
    assign bus.alu_src1     = src1_p1;
    assign bus.alu_src2     = src2_p1;
    assign bus.alu_ctrl     = ctrl_p1;
    assign bus.alu_bonus    = bonus_p1;
    assign bus.alu_cin      = cin_p1;
    assign bus.out_valid    = vld_p2;
    assign bus.out_result   = result_p2;
    assign bus.out_zero     = zero_p2;
    assign bus.out_cout     = cout_p2;
    assign bus.out_overflow = ovf_p2;
    assign bus.out_illegal  = illegal_p2;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage. A behavioural stand-in for the ripple
// ALU closes the loop between alu_* outputs and alu_result/flags.
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failures = 0;

    always #5 clk_i = ~clk_i;

    alu_issue_stage_if #(.WIDTH(32)) bus ();

`ifdef ALU_ISSUE_PERF_EN
    logic [15:0] perf_ops;
    logic [15:0] perf_illegal;
`endif

    alu_issue_stage #(.WIDTH(32)) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .bus          (bus)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_ops     (perf_ops),
        .perf_illegal (perf_illegal)
`endif
    );

    // Reference decoder instance, checked against a hand-written table.
    logic [3:0] ref_op;
    logic [3:0] ref_ctrl;
    logic [2:0] ref_bonus;
    logic       ref_cin;
    logic       ref_illegal;

    alu_op_decode u_ref (
        .op      (ref_op),
        .ctrl    (ref_ctrl),
        .bonus   (ref_bonus),
        .cin     (ref_cin),
        .illegal (ref_illegal)
    );

    // Behavioural ALU: a/b optionally inverted, then AND/OR/SUM/compare.
    logic [31:0] ma, mb, msum, mres;
    logic        mc, mov, mless, meq, mcmp;
    always_comb begin
        ma   = bus.alu_ctrl[3] ? ~bus.alu_src1 : bus.alu_src1;
        mb   = bus.alu_ctrl[2] ? ~bus.alu_src2 : bus.alu_src2;
        {mc, msum} = {1'b0, ma} + {1'b0, mb} + {32'd0, bus.alu_cin};
        mov   = (ma[31] == mb[31]) && (msum[31] != ma[31]);
        mless = msum[31] ^ mov;
        meq   = (msum == 32'd0);
        case (bus.alu_bonus)
            3'b000:  mcmp = mless;
            3'b001:  mcmp = !mless && !meq;
            3'b010:  mcmp = mless || meq;
            3'b011:  mcmp = !mless;
            3'b110:  mcmp = meq;
            3'b100:  mcmp = !meq;
            default: mcmp = 1'b0;
        endcase
        case (bus.alu_ctrl[1:0])
            2'b00:   mres = ma & mb;
            2'b01:   mres = ma | mb;
            2'b10:   mres = msum;
            default: mres = {31'd0, mcmp};
        endcase
        bus.alu_result   = mres;
        bus.alu_zero     = (mres == 32'd0);
        bus.alu_cout     = mc;
        bus.alu_overflow = mov;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_src1  = a;
        bus.in_src2  = b;
    endtask

    // {ctrl, bonus, illegal} per op code
    logic [7:0] exp_tab [16];

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_tab = '{8'b0000_000_0, 8'b0001_000_0, 8'b0010_000_0, 8'b0110_000_0,
                    8'b1100_000_0, 8'b1101_000_0, 8'b0111_000_0, 8'b0111_001_0,
                    8'b0111_010_0, 8'b0111_011_0, 8'b0111_110_0, 8'b0111_100_0,
                    8'b0010_000_1, 8'b0010_000_1, 8'b0010_000_1, 8'b0010_000_1};

        // Decoder table
        for (int i = 0; i < 16; i++) begin
            ref_op = i[3:0];
            #1;
            chk($sformatf("decode_%0d", i), {24'd0, ref_ctrl, ref_bonus, ref_illegal}, {24'd0, exp_tab[i]});
            chk($sformatf("decode_cin_%0d", i), {31'd0, ref_cin}, {31'd0, exp_tab[i][6]});
        end

        // Reset with a request presented
        bus.out_ready = 1'b1;
        drive(1'b1, OP_ADD, 32'd1, 32'd1);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        tick();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
        chk("rst_alu_bonus", {29'd0, bus.alu_bonus}, 32'd0);
        chk("rst_alu_cin", {31'd0, bus.alu_cin}, 32'd0);
        chk("rst_alu_src1", bus.alu_src1, 32'd0);
        chk("rst_alu_src2", bus.alu_src2, 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_out_flags", {28'd0, bus.out_zero, bus.out_cout, bus.out_overflow, bus.out_illegal}, 32'd0);
        chk("rst_in_ready_low", {31'd0, bus.in_ready}, 32'd1);
        drive(1'b0, OP_AND, 32'd0, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("rst_no_capture", {31'd0, bus.out_valid}, 32'd0);

        // ADD overflow
        drive(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1);
        tick();
        chk("add_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'b0010);
        chk("add_alu_cin", {31'd0, bus.alu_cin}, 32'd0);
        chk("add_alu_src1", bus.alu_src1, 32'h7FFF_FFFF);
        chk("add_not_yet", {31'd0, bus.out_valid}, 32'd0);
        drive(1'b0, OP_AND, 32'd0, 32'd0);
        tick();
        chk("add_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("add_result", bus.out_result, 32'h8000_0000);
        chk("add_ovf", {31'd0, bus.out_overflow}, 32'd1);
        chk("add_cout", {31'd0, bus.out_cout}, 32'd0);
        chk("add_illegal", {31'd0, bus.out_illegal}, 32'd0);
        tick();
        chk("add_drained", {31'd0, bus.out_valid}, 32'd0);

        // SUB, SEQ, SNE back to back
        drive(1'b1, OP_SUB, 32'd5, 32'd5);
        tick();
        chk("sub_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'b0110);
        drive(1'b1, OP_SEQ, 32'd5, 32'd5);
        tick();
        chk("sub_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("sub_result", bus.out_result, 32'd0);
        chk("sub_zero", {31'd0, bus.out_zero}, 32'd1);
        chk("seq_bonus", {29'd0, bus.alu_bonus}, 32'b110);
        drive(1'b1, OP_SNE, 32'd5, 32'd5);
        tick();
        chk("seq_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("seq_result", bus.out_result, 32'd1);
        chk("seq_zero", {31'd0, bus.out_zero}, 32'd0);
        chk("sne_bonus", {29'd0, bus.alu_bonus}, 32'b100);
        drive(1'b0, OP_AND, 32'd0, 32'd0);
        tick();
        chk("sne_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("sne_result", bus.out_result, 32'd0);
        tick();
        chk("b2b_drained", {31'd0, bus.out_valid}, 32'd0);

        // SLT / SGE with -1 vs 1
        drive(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
        tick();
        chk("slt_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'b0111);
        chk("slt_alu_cin", {31'd0, bus.alu_cin}, 32'd1);
        drive(1'b1, OP_SGE, 32'hFFFF_FFFF, 32'd1);
        tick();
        chk("slt_result", bus.out_result, 32'd1);
        chk("sge_bonus", {29'd0, bus.alu_bonus}, 32'b011);
        drive(1'b0, OP_AND, 32'd0, 32'd0);
        tick();
        chk("sge_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("sge_result", bus.out_result, 32'd0);
        tick();

        // Stall with three ops offered
        bus.out_ready = 1'b0;
        drive(1'b1, OP_AND, 32'h0000_00F0, 32'h0000_00FF);
        #1;
        chk("stall_ready0", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("stall_ready1", {31'd0, bus.in_ready}, 32'd1);
        drive(1'b1, OP_OR, 32'h0000_000F, 32'h0000_00F0);
        tick();
        chk("stall_ready_drop", {31'd0, bus.in_ready}, 32'd0);
        drive(1'b1, OP_ADD, 32'd1, 32'd2);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("stall_valid_%0d", c), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("stall_result_%0d", c), bus.out_result, 32'h0000_00F0);
            chk($sformatf("stall_s1_%0d", c), bus.alu_src1, 32'h0000_000F);
            chk($sformatf("stall_in_ready_%0d", c), {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("stall_release_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        drive(1'b0, OP_AND, 32'd0, 32'd0);
        chk("stall_op2_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("stall_op2_result", bus.out_result, 32'h0000_00FF);
        tick();
        chk("stall_op3_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("stall_op3_result", bus.out_result, 32'd3);
        tick();
        chk("stall_drained", {31'd0, bus.out_valid}, 32'd0);

        // Illegal op
        drive(1'b1, 4'd13, 32'hA, 32'hB);
        tick();
        chk("ill_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'b0010);
        drive(1'b0, OP_AND, 32'd0, 32'd0);
        tick();
        chk("ill_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("ill_flag", {31'd0, bus.out_illegal}, 32'd1);
        chk("ill_result", bus.out_result, 32'd0);
        chk("ill_flags", {29'd0, bus.out_zero, bus.out_cout, bus.out_overflow}, 32'd0);
        tick();
`ifdef ALU_ISSUE_PERF_EN
        chk("perf_ops", {16'd0, perf_ops}, 32'd10);
        chk("perf_illegal", {16'd0, perf_illegal}, 32'd1);
`endif

        // Reset while two ops are stalled in flight
        bus.out_ready = 1'b0;
        drive(1'b1, OP_OR, 32'h1, 32'h2);
        tick();
        drive(1'b1, OP_NOR, 32'h0, 32'h0);
        tick();
        drive(1'b0, OP_AND, 32'd0, 32'd0);
        chk("mid_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("mid_ready", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("mid_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
        chk("mid_out_result", bus.out_result, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("mid_no_ghost_%0d", c), {31'd0, bus.out_valid}, 32'd0);
        end
`ifdef ALU_ISSUE_PERF_EN
        chk("perf_rst", {perf_ops, perf_illegal}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
